// File: rtl/pedal_pkg.sv
// Shared encodings for the pedal datapath: distortion modes, unity gain
// and the state enums of the frame sequencer.
package pedal_pkg;

  localparam logic [1:0] MODE_CLEAN  = 2'b00;
  localparam logic [1:0] MODE_LIGHT  = 2'b01;
  localparam logic [1:0] MODE_NORMAL = 2'b10;
  localparam logic [1:0] MODE_HEAVY  = 2'b11;

  // Gain is Q1.8, so 256 is exactly unity.
  localparam logic [8:0] GAIN_UNITY = 9'd256;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN_L,
    CH_RUN_R,
    CH_SCALE
  } ch_state_t;

  typedef enum logic [1:0] {
    MD_STEADY,
    MD_FADE_OUT,
    MD_SWAP,
    MD_FADE_IN
  } md_state_t;

  // (x * g) >>> 8 in 26-bit signed arithmetic; g <= 256 keeps the result in range.
  function automatic logic signed [15:0] apply_gain(input logic signed [15:0] x,
                                                    input logic [8:0] g);
    logic signed [25:0] prod;
    prod = x * $signed({1'b0, g});
    return prod[23:8];
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer for the mode switches plus a candidate tracker that
// counts frames, not clocks, before a new switch value is accepted.
module switch_debounce
  import pedal_pkg::*;
#(
  parameter int STABLE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sw_mode,
  input  logic       tick,
  output logic [1:0] cand,
  output logic       accepted
);

  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE_FRAMES);

  logic [1:0]    meta_reg;
  logic [1:0]    req_reg;
  logic [1:0]    cand_reg;
  logic [1:0]    cand_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cand_next = cand_reg;
    cnt_next  = cnt_reg;
    if (tick) begin
      if (req_reg == cand_reg) begin
        if (cnt_reg != STABLE_CNT) cnt_next = cnt_reg + 1'b1;
      end else begin
        cand_next = req_reg;
        cnt_next  = CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= MODE_CLEAN;
      req_reg  <= MODE_CLEAN;
      cand_reg <= MODE_CLEAN;
      cnt_reg  <= '0;
    end else begin
      meta_reg <= sw_mode;
      req_reg  <= meta_reg;
      cand_reg <= cand_next;
      cnt_reg  <= cnt_next;
    end
  end

  // Post-update view, so the mode FSM reacts in the same frame the count matures.
  assign cand     = cand_next;
  assign accepted = (cnt_next == STABLE_CNT);

endmodule

// File: rtl/distortion_sequencer.sv
// Time-multiplexes one shared distortion instance across left/right and
// ramps the output gain around every accepted mode change.
module distortion_sequencer
  import pedal_pkg::*;
#(
  parameter int STABLE_FRAMES = 4,
  parameter int RAMP_STEP     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         sw_mode,
  input  logic               sample_valid,
  input  logic signed [15:0] left_in,
  input  logic signed [15:0] right_in,
  output logic signed [15:0] dist_in,
  output logic [1:0]         dist_mode,
  input  logic signed [15:0] dist_out,
  output logic signed [15:0] left_out,
  output logic signed [15:0] right_out,
  output logic               out_valid,
  output logic [1:0]         mode_active,
  output logic               fading,
  output logic               overrun
);

  localparam logic [8:0] STEP = 9'(RAMP_STEP);

  ch_state_t ch_state_reg, ch_state_next;
  md_state_t md_state_reg, md_state_next;

  logic signed [15:0] l_reg, r_reg, l_proc_reg, r_proc_reg;
  logic signed [15:0] left_out_reg, right_out_reg;
  logic               out_valid_reg, overrun_reg;
  logic [8:0]         gain_reg, gain_next, gain_dec, gain_inc;
  logic [9:0]         gain_sum;
  logic [1:0]         mode_reg, mode_next;
  logic [1:0]         cand;
  logic               accepted;
  logic               tick;

  assign tick = (ch_state_reg == CH_SCALE);

  switch_debounce #(
    .STABLE_FRAMES(STABLE_FRAMES)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_mode (sw_mode),
    .tick    (tick),
    .cand    (cand),
    .accepted(accepted)
  );

  always_comb begin
    ch_state_next = ch_state_reg;
    dist_in       = '0;
    case (ch_state_reg)
      CH_IDLE:  if (sample_valid) ch_state_next = CH_RUN_L;
      CH_RUN_L: begin
        dist_in       = l_reg;
        ch_state_next = CH_RUN_R;
      end
      CH_RUN_R: begin
        dist_in       = r_reg;
        ch_state_next = CH_SCALE;
      end
      default:  ch_state_next = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_state_reg  <= CH_IDLE;
      l_reg         <= '0;
      r_reg         <= '0;
      l_proc_reg    <= '0;
      r_proc_reg    <= '0;
      left_out_reg  <= '0;
      right_out_reg <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      ch_state_reg  <= ch_state_next;
      out_valid_reg <= tick;
      if (sample_valid && ch_state_reg != CH_IDLE) overrun_reg <= 1'b1;
      case (ch_state_reg)
        CH_IDLE: if (sample_valid) begin
          l_reg <= left_in;
          r_reg <= right_in;
        end
        CH_RUN_L: l_proc_reg <= dist_out;
        CH_RUN_R: r_proc_reg <= dist_out;
        default: begin
          left_out_reg  <= apply_gain(l_proc_reg, gain_reg);
          right_out_reg <= apply_gain(r_proc_reg, gain_reg);
        end
      endcase
    end
  end

  // Saturating ramp arithmetic; the mode FSM picks whichever it needs.
  assign gain_dec = (gain_reg > STEP) ? (gain_reg - STEP) : 9'd0;
  assign gain_sum = {1'b0, gain_reg} + {1'b0, STEP};
  assign gain_inc = (gain_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum[8:0];

  always_comb begin
    md_state_next = md_state_reg;
    gain_next     = gain_reg;
    mode_next     = mode_reg;
    if (tick) begin
      case (md_state_reg)
        MD_STEADY: if (accepted && cand != mode_reg) md_state_next = MD_FADE_OUT;
        MD_FADE_OUT: begin
          if (accepted && cand == mode_reg) begin
            md_state_next = MD_FADE_IN;
          end else begin
            gain_next = gain_dec;
            if (gain_dec == 9'd0) md_state_next = MD_SWAP;
          end
        end
        MD_SWAP: begin
          mode_next     = cand;
          md_state_next = MD_FADE_IN;
        end
        default: begin
          if (accepted && cand != mode_reg) begin
            md_state_next = MD_FADE_OUT;
          end else begin
            gain_next = gain_inc;
            if (gain_inc == GAIN_UNITY) md_state_next = MD_STEADY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_state_reg <= MD_STEADY;
      gain_reg     <= GAIN_UNITY;
      mode_reg     <= MODE_CLEAN;
    end else begin
      md_state_reg <= md_state_next;
      gain_reg     <= gain_next;
      mode_reg     <= mode_next;
    end
  end

  assign dist_mode   = mode_reg;
  assign mode_active = mode_reg;
  assign fading      = (md_state_reg != MD_STEADY);
  assign left_out    = left_out_reg;
  assign right_out   = right_out_reg;
  assign out_valid   = out_valid_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_distortion_sequencer.sv
// Directed bench for distortion_sequencer with a behavioural distortion
// stand-in driving dist_out from dist_in/dist_mode.
module tb_distortion_sequencer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         sw_mode;
  logic               sample_valid;
  logic signed [15:0] left_in, right_in;
  logic signed [15:0] dist_in;
  logic [1:0]         dist_mode;
  logic signed [15:0] dist_out;
  logic signed [15:0] left_out, right_out;
  logic               out_valid;
  logic [1:0]         mode_active;
  logic               fading;
  logic               overrun;

  int checks = 0;
  int errors = 0;
  int ov_count = 0;

  always #5 clk = ~clk;

  distortion_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_mode     (sw_mode),
    .sample_valid(sample_valid),
    .left_in     (left_in),
    .right_in    (right_in),
    .dist_in     (dist_in),
    .dist_mode   (dist_mode),
    .dist_out    (dist_out),
    .left_out    (left_out),
    .right_out   (right_out),
    .out_valid   (out_valid),
    .mode_active (mode_active),
    .fading      (fading),
    .overrun     (overrun)
  );

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Stand-in distortion curves; only need to differ per mode.
  function automatic int dmodel(input logic [1:0] m, input int x);
    case (m)
      2'b00:   return x;
      2'b01:   return sat16((x * 11) / 6);
      2'b10:   return sat16(x * 3);
      default: return (x >= 0) ? 32767 : -32768;
    endcase
  endfunction

  function automatic int scale(input int v, input int g);
    return (v * g) >>> 8;
  endfunction

  // Gain used by frame k of the 00->01 change (hand-derived ramp schedule).
  function automatic int exp_gain(input int k);
    if (k <= 5)  return 256;
    if (k <= 21) return 256 - 16 * (k - 5);
    if (k <= 37) return 16 * (k - 22);
    return 256;
  endfunction

  assign dist_out = 16'(dmodel(dist_mode, int'(dist_in)));

  always @(negedge clk) if (out_valid) ov_count++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after out_valid (or the timeout).
  task automatic frame(input int l, input int r, output int lo, output int ro, output int lat);
    left_in      = 16'(l);
    right_in     = 16'(r);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    lat = 0;
    lo  = 0;
    ro  = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) chk("dist_in_l", int'(dist_in), l);
      if (i == 2) chk("dist_in_r", int'(dist_in), r);
      if (out_valid) begin
        lat = i;
        lo  = int'(left_out);
        ro  = int'(right_out);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, ro, lat, ovb, g, m;
    rst_n = 1'b0; sw_mode = 2'b00; sample_valid = 1'b0; left_in = '0; right_in = '0;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_left_out", int'(left_out), 0);
    chk("rst_right_out", int'(right_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_mode", int'(mode_active), 0);
    chk("rst_fading", int'(fading), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_dist_in", int'(dist_in), 0);
    $display("reset checked");

    ovb = ov_count;
    frame(1000, -1000, lo, ro, lat);
    chk("clean_lat", lat, 4);
    chk("clean_l", lo, 1000);
    chk("clean_r", ro, -1000);
    chk("clean_one_valid", ov_count - ovb, 1);
    $display("frame clean l=%0d r=%0d lat=%0d", lo, ro, lat);

    // Mode change 00 -> 01 through the full fade.
    sw_mode = 2'b01;
    repeat (3) @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      frame(12000, -12001, lo, ro, lat);
      g = exp_gain(k);
      m = (k <= 21) ? 0 : 1;
      chk($sformatf("ramp%0d_lat", k), lat, 4);
      chk($sformatf("ramp%0d_l", k), lo, scale(dmodel(2'(m), 12000), g));
      chk($sformatf("ramp%0d_r", k), ro, scale(dmodel(2'(m), -12001), g));
      chk($sformatf("ramp%0d_fading", k), int'(fading), (k >= 4 && k <= 36) ? 1 : 0);
      chk($sformatf("ramp%0d_mode", k), int'(mode_active), (k >= 21) ? 1 : 0);
      if (k == 38) chk("first_steady_l", lo, 22000);
      $display("frame ramp k=%0d l=%0d r=%0d mode=%0d fading=%0d", k, lo, ro, mode_active, fading);
    end

    // Two-frame glitch on the switch must be ignored.
    sw_mode = 2'b11;
    repeat (3) @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        sw_mode = 2'b01;
        repeat (3) @(posedge clk); #1;
      end
      frame(12000, 12000, lo, ro, lat);
      chk($sformatf("pulse%0d_fading", k), int'(fading), 0);
      chk($sformatf("pulse%0d_mode", k), int'(mode_active), 1);
      chk($sformatf("pulse%0d_l", k), lo, 22000);
      $display("frame pulse k=%0d l=%0d mode=%0d fading=%0d", k, lo, mode_active, fading);
    end

    // Second strobe during RUN_R is dropped and flagged.
    ovb = ov_count;
    left_in = 16'sd500; right_in = 16'sd500; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("overrun_one_valid", ov_count - ovb, 1);
    chk("overrun_flag", int'(overrun), 1);
    frame(0, 0, lo, ro, lat);
    chk("overrun_next_lat", lat, 4);
    chk("overrun_sticky", int'(overrun), 1);
    $display("overrun valid_count=%0d overrun=%0d", ov_count - ovb, overrun);

    // Fade toward 10 down to gain 128, then reset mid-frame.
    sw_mode = 2'b10;
    repeat (3) @(posedge clk); #1;
    for (int k = 1; k <= 12; k++) frame(1000, -1000, lo, ro, lat);
    chk("prefade_l", lo, scale(dmodel(2'b01, 1000), 144));
    chk("prefade_fading", int'(fading), 1);
    $display("frame prefade l=%0d fading=%0d", lo, fading);
    left_in = 16'sd5000; right_in = 16'sd5000; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    rst_n = 1'b0;
    ovb = ov_count;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("midrst_no_valid", ov_count - ovb, 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_mode", int'(mode_active), 0);
    chk("midrst_fading", int'(fading), 0);
    chk("midrst_left_out", int'(left_out), 0);
    $display("mid-fade reset checked");
    for (int k = 1; k <= 4; k++) begin
      frame(1000, -1000, lo, ro, lat);
      if (k == 1) begin
        chk("postrst_l", lo, 1000);
        chk("postrst_r", ro, -1000);
      end
      chk($sformatf("postrst%0d_fading", k), int'(fading), (k == 4) ? 1 : 0);
      $display("frame postrst k=%0d l=%0d fading=%0d", k, lo, fading);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
